// File: rtl/mmio_ws_pkg.sv
// mmio_ws_pkg: shared types and constants for the MMIO wait-state controller.
//   state_t      : controller FSM state encoding
//   SLOT_W       : width of the slot index field of the word address
//   REG_W        : width of the per-slot register address field
//   TIMEOUT_DATA : read data returned when a slot never completes
package mmio_ws_pkg;

   localparam int SLOT_W = 6;
   localparam int REG_W  = 5;
   localparam logic [31:0] TIMEOUT_DATA = 32'hDEAD_BEEF;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ISSUE = 2'd1,
      WAIT  = 2'd2,
      RESP  = 2'd3
   } state_t;

endpackage

// File: rtl/mmio_ws_ctrl_if.sv
// mmio_ws_ctrl_if: host-side MMIO bus between a bus master and mmio_ws_ctrl.
//   mmio_cs/mmio_rd/mmio_wr : request qualifiers (master -> slave)
//   mmio_addr[20:0]         : word address, [10:5] slot, [4:0] register
//   mmio_wr_data[31:0]      : write data
//   mmio_rd_data[31:0]      : registered read data (slave -> master)
//   mmio_ready              : one-cycle transaction-complete pulse
interface mmio_ws_ctrl_if;

   logic        mmio_cs;
   logic        mmio_rd;
   logic        mmio_wr;
   logic [20:0] mmio_addr;
   logic [31:0] mmio_wr_data;
   logic [31:0] mmio_rd_data;
   logic        mmio_ready;

   modport master (
      output mmio_cs, mmio_rd, mmio_wr, mmio_addr, mmio_wr_data,
      input  mmio_rd_data, mmio_ready
   );

   modport slave (
      input  mmio_cs, mmio_rd, mmio_wr, mmio_addr, mmio_wr_data,
      output mmio_rd_data, mmio_ready
   );

endinterface

// File: rtl/mmio_ws_timeout_cnt.sv
// mmio_ws_timeout_cnt: per-transaction wait counter.
//   clk, reset : clock, synchronous active-high reset
//   clear      : restart the count (transaction issue cycle)
//   enable     : one more wait cycle without acknowledge
//   expired    : this enabled cycle is wait cycle number TIMEOUT
module mmio_ws_timeout_cnt #(
   parameter int TIMEOUT = 255
) (
   input  logic clk,
   input  logic reset,
   input  logic clear,
   input  logic enable,
   output logic expired
);

   logic [15:0] cnt_q;
   logic [15:0] cnt_d;

   always_comb begin
      cnt_d = cnt_q;
      if (clear) begin
         cnt_d = '0;
      end else if (enable) begin
         cnt_d = cnt_q + 16'd1;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   // Terminal compare on the pre-increment value, so expiry is flagged in
   // the TIMEOUT-th wait cycle itself rather than one cycle later.
   assign expired = enable && (cnt_q == 16'(TIMEOUT - 1));

endmodule

// File: rtl/mmio_ws_ctrl.sv
// mmio_ws_ctrl: MMIO slot decoder with per-slot wait states.
//   clk, reset     : clock, synchronous active-high reset
//   bus            : host MMIO bus (mmio_ws_ctrl_if.slave)
//   busy           : transaction in flight (accept+1 .. ready)
//   slot_cs        : one-hot slot select, N_SLOTS wide
//   slot_rd/wr     : one-cycle broadcast strobes
//   slot_reg_addr  : broadcast register address
//   slot_wr_data   : broadcast write data
//   slot_rd_data   : flattened slot read data, slot k at [32k+31:32k]
//   slot_ack       : per-slot completion
//   bus_err        : error pulse, coincident with mmio_ready
//   err_slot       : sticky slot index of the latest error
// Build option: define MMIO_WS_TIMEOUT_EN to bound WAIT to TIMEOUT cycles.
//
// state | meaning
// IDLE  | waiting for a bus request
// ISSUE | strobe to the selected slot, sample its ack
// WAIT  | slot selected, waiting for its ack (or timeout)
// RESP  | mmio_ready pulse with captured data / error
module mmio_ws_ctrl
   import mmio_ws_pkg::*;
#(
   parameter int N_SLOTS = 64,
   parameter int TIMEOUT = 255
) (
   input  logic                    clk,
   input  logic                    reset,
   mmio_ws_ctrl_if.slave           bus,
   output logic                    busy,
   output logic [N_SLOTS-1:0]      slot_cs,
   output logic                    slot_rd,
   output logic                    slot_wr,
   output logic [REG_W-1:0]        slot_reg_addr,
   output logic [31:0]             slot_wr_data,
   input  logic [N_SLOTS*32-1:0]   slot_rd_data,
   input  logic [N_SLOTS-1:0]      slot_ack,
   output logic                    bus_err,
   output logic [SLOT_W-1:0]       err_slot
);

   state_t            state_q, state_d;
   logic [SLOT_W-1:0] idx_q, idx_d;
   logic [REG_W-1:0]  reg_q, reg_d;
   logic [31:0]       wdata_q, wdata_d;
   logic              is_wr_q, is_wr_d;
   logic [31:0]       rdata_q, rdata_d;
   logic              err_q, err_d;
   logic [SLOT_W-1:0] err_slot_q, err_slot_d;

   logic              in_range;
   logic [63:0]       ack_ext;
   logic [64*32-1:0]  rd_ext;
   logic              ack_sel;
   logic [31:0]       sel_data;
   logic              expired;

   // Widen to the full 64-slot space so an undecoded index selects zeros
   // instead of indexing past the real ports.
   assign in_range = (32'(idx_q) < N_SLOTS);
   assign ack_ext  = 64'(slot_ack);
   assign rd_ext   = (64*32)'(slot_rd_data);
   assign ack_sel  = in_range && ack_ext[idx_q];
   assign sel_data = rd_ext[{idx_q, 5'b0} +: 32];

`ifdef MMIO_WS_TIMEOUT_EN
   logic cnt_clear;
   logic cnt_en;

   assign cnt_clear = (state_q == ISSUE);
   assign cnt_en    = (state_q == WAIT) && !ack_sel;

   mmio_ws_timeout_cnt #(
      .TIMEOUT (TIMEOUT)
   ) u_timeout_cnt (
      .clk     (clk),
      .reset   (reset),
      .clear   (cnt_clear),
      .enable  (cnt_en),
      .expired (expired)
   );
`else
   logic unused_timeout;
   assign unused_timeout = (TIMEOUT != 0);
   assign expired        = 1'b0;
`endif

   // Address bits above the slot field are not decoded.
   logic unused_addr;
   assign unused_addr = ^bus.mmio_addr[20:11];

   always_comb begin
      state_d    = state_q;
      idx_d      = idx_q;
      reg_d      = reg_q;
      wdata_d    = wdata_q;
      is_wr_d    = is_wr_q;
      rdata_d    = rdata_q;
      err_d      = err_q;
      err_slot_d = err_slot_q;
      unique case (state_q)
         IDLE: begin
            if (bus.mmio_cs && (bus.mmio_rd || bus.mmio_wr)) begin
               idx_d   = bus.mmio_addr[10:5];
               reg_d   = bus.mmio_addr[4:0];
               wdata_d = bus.mmio_wr_data;
               is_wr_d = bus.mmio_wr;
               state_d = ISSUE;
            end
         end
         ISSUE, WAIT: begin
            if ((state_q == ISSUE) && !in_range) begin
               rdata_d    = '0;
               err_d      = 1'b1;
               err_slot_d = idx_q;
               state_d    = RESP;
            end else if (ack_sel) begin
               // An ack on the expiry cycle takes priority over the timeout.
               rdata_d = is_wr_q ? 32'd0 : sel_data;
               err_d   = 1'b0;
               state_d = RESP;
            end else if (expired) begin
               rdata_d    = TIMEOUT_DATA;
               err_d      = 1'b1;
               err_slot_d = idx_q;
               state_d    = RESP;
            end else begin
               state_d = WAIT;
            end
         end
         RESP: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q    <= IDLE;
         idx_q      <= '0;
         reg_q      <= '0;
         wdata_q    <= '0;
         is_wr_q    <= 1'b0;
         rdata_q    <= '0;
         err_q      <= 1'b0;
         err_slot_q <= '0;
      end else begin
         state_q    <= state_d;
         idx_q      <= idx_d;
         reg_q      <= reg_d;
         wdata_q    <= wdata_d;
         is_wr_q    <= is_wr_d;
         rdata_q    <= rdata_d;
         err_q      <= err_d;
         err_slot_q <= err_slot_d;
      end
   end

   // An undecoded index shifts the one-hot bit out of range, leaving slot_cs 0.
   assign slot_cs = ((state_q == ISSUE) || (state_q == WAIT)) ?
                    (N_SLOTS'(1) << idx_q) : '0;
   assign slot_rd       = (state_q == ISSUE) && !is_wr_q;
   assign slot_wr       = (state_q == ISSUE) && is_wr_q;
   assign slot_reg_addr = reg_q;
   assign slot_wr_data  = wdata_q;

   assign busy             = (state_q != IDLE);
   assign bus.mmio_ready   = (state_q == RESP);
   assign bus.mmio_rd_data = rdata_q;
   assign bus_err          = (state_q == RESP) && err_q;
   assign err_slot         = err_slot_q;

endmodule
